// File: rtl/fg_prog_sequencer_if.sv
// rtl/fg_prog_sequencer_if.sv - command channel into the floating-gate programming sequencer
interface fg_prog_sequencer_if #(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 4,
    parameter int PW_W     = 16,
    parameter int CNT_W    = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_mode;
    logic [ROW_BITS-1:0] cmd_row;
    logic [COL_BITS-1:0] cmd_col;
    logic [CNT_W-1:0]    cmd_pulses;
    logic [PW_W-1:0]     cmd_width;

    modport master (
        output cmd_valid, cmd_mode, cmd_row, cmd_col, cmd_pulses, cmd_width,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_row, cmd_col, cmd_pulses, cmd_width,
        output cmd_ready
    );
endinterface

// File: rtl/fg_prog_sequencer.sv
// rtl/fg_prog_sequencer.sv - settle/pulse-train/read/release sequencer for one FG island; FG_PROG_ABORT_EN adds abort input
module fg_prog_sequencer #(
    parameter int ROW_BITS   = 2,
    parameter int COL_BITS   = 4,
    parameter int PW_W       = 16,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 8,
    parameter int GAP_CYC    = 4
) (
    input  logic                clk,
    input  logic                reset,
`ifdef FG_PROG_ABORT_EN
    input  logic                abort,
`endif
    fg_prog_sequencer_if.slave  cmd,
    output logic [ROW_BITS-1:0] row_addr,
    output logic [COL_BITS-1:0] col_addr,
    output logic                dec_en,
    output logic                prog_sw_en,
    output logic                drain_sel_en,
    output logic                gate_sel_en,
    output logic                inj_pulse,
    output logic                tun_pulse,
    output logic                meas_strobe,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int TMR_MAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [1:0] MODE_INJ  = 2'b00;
    localparam logic [1:0] MODE_READ = 2'b10;
    localparam logic [1:0] MODE_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, GAP, MEASURE, RELEASE, DONE
    } state_t;

    state_t            state;
    logic [1:0]        mode_q;
    logic [PW_W-1:0]   width_q;
    logic [CNT_W-1:0]  remain_q;
    logic [PW_W-1:0]   pw_cnt;
    logic [TMR_W-1:0]  tmr;
    logic              en_q;
    logic              aborted_q;
    logic              abort_req;
    logic [PW_W-1:0]   width_m1;

`ifdef FG_PROG_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // A zero width still produces a one-cycle pulse; pw_cnt holds cycles left after the current one.
    assign width_m1 = (width_q == '0) ? '0 : width_q - PW_W'(1);

    assign cmd.cmd_ready  = (state == IDLE) && !reset;
    assign busy           = (state != IDLE);
    assign dec_en         = en_q;
    assign prog_sw_en     = en_q;
    assign drain_sel_en   = en_q;
    assign gate_sel_en    = en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= '0;
            width_q     <= '0;
            remain_q    <= '0;
            pw_cnt      <= '0;
            tmr         <= '0;
            en_q        <= 1'b0;
            aborted_q   <= 1'b0;
            row_addr    <= '0;
            col_addr    <= '0;
            inj_pulse   <= 1'b0;
            tun_pulse   <= 1'b0;
            meas_strobe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done        <= 1'b0;
            meas_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        mode_q   <= cmd.cmd_mode;
                        width_q  <= cmd.cmd_width;
                        remain_q <= cmd.cmd_pulses;
                        if (cmd.cmd_mode == MODE_ILL ||
                            (cmd.cmd_mode != MODE_READ && cmd.cmd_pulses == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state    <= SETUP;
                            row_addr <= cmd.cmd_row;
                            col_addr <= cmd.cmd_col;
                            en_q     <= 1'b1;
                            err      <= 1'b0;
                            tmr      <= TMR_W'(SETTLE_CYC - 1);
                        end
                    end
                end
                SETUP: begin
                    if (abort_req) begin
                        state     <= RELEASE;
                        en_q      <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (tmr == '0) begin
                        if (mode_q == MODE_READ) begin
                            state       <= MEASURE;
                            meas_strobe <= 1'b1;
                        end else begin
                            state     <= PULSE;
                            inj_pulse <= (mode_q == MODE_INJ);
                            tun_pulse <= (mode_q != MODE_INJ);
                            pw_cnt    <= width_m1;
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                PULSE: begin
                    if (abort_req) begin
                        state     <= RELEASE;
                        en_q      <= 1'b0;
                        inj_pulse <= 1'b0;
                        tun_pulse <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (pw_cnt == '0) begin
                        state     <= GAP;
                        inj_pulse <= 1'b0;
                        tun_pulse <= 1'b0;
                        remain_q  <= remain_q - CNT_W'(1);
                        tmr       <= TMR_W'(GAP_CYC - 1);
                    end else begin
                        pw_cnt <= pw_cnt - PW_W'(1);
                    end
                end
                GAP: begin
                    if (abort_req) begin
                        state     <= RELEASE;
                        en_q      <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (tmr == '0) begin
                        if (remain_q != '0) begin
                            state     <= PULSE;
                            inj_pulse <= (mode_q == MODE_INJ);
                            tun_pulse <= (mode_q != MODE_INJ);
                            pw_cnt    <= width_m1;
                        end else begin
                            state <= RELEASE;
                            en_q  <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                MEASURE: begin
                    state     <= RELEASE;
                    en_q      <= 1'b0;
                    aborted_q <= abort_req;
                end
                RELEASE: begin
                    state    <= DONE;
                    done     <= 1'b1;
                    err      <= aborted_q;
                    row_addr <= '0;
                    col_addr <= '0;
                end
                DONE: begin
                    state     <= IDLE;
                    err       <= 1'b0;
                    aborted_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    en_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fg_prog_sequencer.sv
// tb/tb_fg_prog_sequencer.sv - randomized cycle-by-cycle check of fg_prog_sequencer against a timeline model
module tb_fg_prog_sequencer;
    localparam int ROW_BITS = 2;
    localparam int COL_BITS = 4;
    localparam int PW_W     = 16;
    localparam int CNT_W    = 8;
    localparam int SETTLE   = 8;
    localparam int GAP      = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

`ifdef FG_PROG_ABORT_EN
    logic abort = 1'b0;
`endif

    fg_prog_sequencer_if #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .PW_W(PW_W), .CNT_W(CNT_W)) cmd_if ();

    logic [ROW_BITS-1:0] row_addr;
    logic [COL_BITS-1:0] col_addr;
    logic dec_en, prog_sw_en, drain_sel_en, gate_sel_en;
    logic inj_pulse, tun_pulse, meas_strobe, busy, done, err;

    fg_prog_sequencer #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .PW_W(PW_W), .CNT_W(CNT_W),
        .SETTLE_CYC(SETTLE), .GAP_CYC(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef FG_PROG_ABORT_EN
        .abort(abort),
`endif
        .cmd(cmd_if.slave),
        .row_addr(row_addr),
        .col_addr(col_addr),
        .dec_en(dec_en),
        .prog_sw_en(prog_sw_en),
        .drain_sel_en(drain_sel_en),
        .gate_sel_en(gate_sel_en),
        .inj_pulse(inj_pulse),
        .tun_pulse(tun_pulse),
        .meas_strobe(meas_strobe),
        .busy(busy),
        .done(done),
        .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {cmd_ready,busy,done,err,dec,prog_sw,drain,gate,inj,tun,meas,row[1:0],col[3:0]}
    function automatic logic [31:0] observed();
        return {15'd0, cmd_if.cmd_ready, busy, done, err, dec_en, prog_sw_en, drain_sel_en,
                gate_sel_en, inj_pulse, tun_pulse, meas_strobe, row_addr, col_addr};
    endfunction

    localparam logic [31:0] IDLE_VEC = 32'h1_0000;

    function automatic bit is_legal(input int mode, input int n);
        return (mode != 3) && (mode == 2 || n != 0);
    endfunction

    // Cycle on which done is expected, counting the cycle after the accepting edge as 1.
    function automatic int done_cycle(input int mode, input int n, input int w, input int ab);
        int we, rel;
        if (!is_legal(mode, n)) return 1;
        we  = (w == 0) ? 1 : w;
        rel = (mode == 2) ? SETTLE + 2 : SETTLE + n * (we + GAP) + 1;
        if (ab > 0 && ab < rel) rel = ab + 1;
        return rel + 1;
    endfunction

    function automatic logic [31:0] model(input int c, input int mode, input int row, input int col,
                                          input int n, input int w, input int ab);
        int  we, p, dn, rel, k;
        bit  legal, aborted, act, pon, ms, busy_e, addr_on, done_e, err_e;
        legal   = is_legal(mode, n);
        we      = (w == 0) ? 1 : w;
        p       = we + GAP;
        dn      = done_cycle(mode, n, w, ab);
        rel     = legal ? dn - 1 : 0;
        aborted = legal && ab > 0 && ab < ((mode == 2) ? SETTLE + 2 : SETTLE + n * p + 1);
        act     = legal && c >= 1 && c < rel;
        pon     = 1'b0;
        if (act && mode != 2 && c > SETTLE) begin
            k   = c - SETTLE - 1;
            pon = ((k % p) < we) && ((k / p) < n);
        end
        ms      = act && mode == 2 && c == SETTLE + 1;
        busy_e  = c >= 1 && c <= dn;
        addr_on = legal && c >= 1 && c <= rel;
        done_e  = c == dn;
        err_e   = done_e && (!legal || aborted);
        return {15'd0, !busy_e, busy_e, done_e, err_e, act, act, act, act,
                pon && mode == 0, pon && mode == 1, ms,
                addr_on ? row[1:0] : 2'd0, addr_on ? col[3:0] : 4'd0};
    endfunction

    // Entered and left on a negedge with the DUT idle.
    task automatic run_cmd(input int id, input int mode, input int row, input int col,
                           input int n, input int w, input int ab, input int rc);
        int dn;
        dn = done_cycle(mode, n, w, ab);
        check($sformatf("cmd%0d ready", id), {31'd0, cmd_if.cmd_ready}, 32'd1);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_mode   = 2'(mode);
        cmd_if.cmd_row    = ROW_BITS'(row);
        cmd_if.cmd_col    = COL_BITS'(col);
        cmd_if.cmd_pulses = CNT_W'(n);
        cmd_if.cmd_width  = PW_W'(w);
        @(negedge clk);
        for (int c = 1; c <= dn + 1; c++) begin
            if (rc != 0 && c == rc + 1) begin
                check($sformatf("cmd%0d rst c%0d", id, c), observed(), 32'd0);
                reset = 1'b0;
                cmd_if.cmd_valid = 1'b0;
`ifdef FG_PROG_ABORT_EN
                abort = 1'b0;
`endif
                @(negedge clk);
                check($sformatf("cmd%0d post-rst", id), observed(), IDLE_VEC);
                return;
            end
            check($sformatf("cmd%0d m%0d n%0d w%0d c%0d", id, mode, n, w, c), observed(),
                  model(c, mode, row, col, n, w, ab));
            if (c == dn + 1) break;
            cmd_if.cmd_valid = (c < dn) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_if.cmd_mode  = 2'($urandom);
            cmd_if.cmd_row   = ROW_BITS'($urandom);
            cmd_if.cmd_col   = COL_BITS'($urandom);
            cmd_if.cmd_pulses = CNT_W'($urandom);
            cmd_if.cmd_width = PW_W'($urandom);
`ifdef FG_PROG_ABORT_EN
            abort = (c == ab);
`endif
            reset = (rc != 0 && c == rc);
            @(negedge clk);
        end
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        int mode, n, w, ab, rc;
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_mode   = 2'b00;
        cmd_if.cmd_row    = 2'd1;
        cmd_if.cmd_col    = 4'd3;
        cmd_if.cmd_pulses = 8'd2;
        cmd_if.cmd_width  = 16'd2;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset outputs", observed(), 32'd0);
        end
        reset = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("after reset", observed(), IDLE_VEC);

`ifdef FG_PROG_ABORT_EN
        abort = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort idle", observed(), IDLE_VEC);
        end
        abort = 1'b0;
`endif

        run_cmd(0, 0, 2, 9, 3, 5, 0, 0);
        run_cmd(1, 2, 1, 15, 0, 0, 0, 0);
        run_cmd(2, 3, 1, 1, 3, 5, 0, 0);
        run_cmd(3, 0, 1, 1, 0, 5, 0, 0);
        run_cmd(4, 1, 3, 0, 2, 0, 0, 0);
        run_cmd(5, 0, 2, 9, 3, 5, 0, 11);
        run_cmd(6, 0, 2, 9, 3, 5, 0, 0);
`ifdef FG_PROG_ABORT_EN
        run_cmd(7, 0, 2, 9, 3, 5, 19, 0);
        run_cmd(8, 2, 0, 5, 0, 0, 9, 0);
`endif
        run_cmd(9, 0, 1, 1, 255, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            n    = $urandom_range(0, 4);
            w    = $urandom_range(0, 6);
            ab   = 0;
`ifdef FG_PROG_ABORT_EN
            if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, 60);
`endif
            rc   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 30) : 0;
            run_cmd(100 + i, mode, $urandom_range(0, 3), $urandom_range(0, 15), n, w, ab, rc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
